multicycle_decoder: RTL and testbench

MULTICYCLE_DECODER -- requirements
Module: multicycle_decoder

---
 rtl/multicycle_decoder.sv | 251 +++++++++++++++++++++++++
 tb/tb_multicycle_decoder.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_decoder.sv
// ---------------------------------------------------------------------------
// multicycle_decoder
//   Control FSM for a multicycle MIPS-style datapath. Steps each instruction
//   through FETCH / DECODE / execute / memory / write-back states and drives
//   the datapath control strobes, and counts retired instructions.
//
// Optional feature:
//   MULTICYCLE_DECODER_JUMP_EN  - when defined, opcode 0x02 (j) is executed
//                                 through the JUMP state; when undefined it
//                                 is treated as illegal and jump_o is 0.
//
// Parameters:
//   ALU_OP_W  ALU operation code width (>= 3); 3-bit codes are zero-extended
//   CNT_W     retired-instruction counter width
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   instr_op_i     opcode field, captured in FETCH when mem_ready_i=1
//   mem_ready_i    memory access completes this cycle
//   pc_write_o .. illegal_o   datapath control strobes
//   alu_op_o       ALU operation
//   state_o        current state encoding
//   instr_cnt_o    retired-instruction count (wraps)
// ---------------------------------------------------------------------------
module multicycle_decoder #(
  parameter int ALU_OP_W = 3,
  parameter int CNT_W    = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [5:0]          instr_op_i,
  input  logic                mem_ready_i,
  output logic                pc_write_o,
  output logic                ir_write_o,
  output logic                mem_read_o,
  output logic                mem_write_o,
  output logic                reg_write_o,
  output logic                reg_dst_o,
  output logic                alu_src_o,
  output logic                mem_to_reg_o,
  output logic                branch_o,
  output logic                jump_o,
  output logic                illegal_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic [3:0]          state_o,
  output logic [CNT_W-1:0]    instr_cnt_o
);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC_R   = 4'd3,
    ST_EXEC_I   = 4'd4,
    ST_MEM_ADDR = 4'd5,
    ST_MEM_RD   = 4'd6,
    ST_MEM_WB   = 4'd7,
    ST_MEM_WR   = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JUMP     = 4'd10,
    ST_WB       = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
`ifdef MULTICYCLE_DECODER_JUMP_EN
  localparam logic [5:0] OP_J     = 6'h02;
`endif

  localparam logic [2:0] ALU_RTYPE = 3'b010;  // ALU takes function from funct field
  localparam logic [2:0] ALU_SLT   = 3'b011;
  localparam logic [2:0] ALU_ADD   = 3'b100;
  localparam logic [2:0] ALU_SUB   = 3'b101;  // beq compare

  state_e           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;
  logic [2:0]       alu_op3;

  // Opcodes this build knows how to execute.
  function automatic logic is_legal(input logic [5:0] op);
    logic ok;
    ok = (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_SLTI) ||
         (op == OP_LW)    || (op == OP_SW)   || (op == OP_BEQ);
`ifdef MULTICYCLE_DECODER_JUMP_EN
    ok = ok || (op == OP_J);
`endif
    return ok;
  endfunction

  // I-type ALU code shared by EXEC_I and the following WB.
  function automatic logic [2:0] itype_alu(input logic [5:0] op);
    return (op == OP_SLTI) ? ALU_SLT : ALU_ADD;
  endfunction

  // -------------------------------------------------------------------------
  // Next-state, opcode capture and retire detection
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    retire  = 1'b0;
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready_i) begin
          op_d    = instr_op_i;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (op_q)
          OP_RTYPE:         state_d = ST_EXEC_R;
          OP_ADDI, OP_SLTI: state_d = ST_EXEC_I;
          OP_LW, OP_SW:     state_d = ST_MEM_ADDR;
          OP_BEQ:           state_d = ST_BRANCH;
`ifdef MULTICYCLE_DECODER_JUMP_EN
          OP_J:             state_d = ST_JUMP;
`endif
          default:          state_d = ST_FETCH;  // illegal: not retired
        endcase
      end
      ST_EXEC_R, ST_EXEC_I: state_d = ST_WB;
      ST_WB: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      // Only lw and sw reach MEM_ADDR, so anything not sw is a load.
      ST_MEM_ADDR: state_d = (op_q == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD: begin
        if (mem_ready_i) state_d = ST_MEM_WB;
      end
      ST_MEM_WB: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      ST_MEM_WR: begin
        if (mem_ready_i) begin
          state_d = ST_FETCH;
          retire  = 1'b1;
        end
      end
      ST_BRANCH: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
`ifdef MULTICYCLE_DECODER_JUMP_EN
      ST_JUMP: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
`endif
      // Unused encodings (and JUMP when the feature is off) recover to FETCH.
      default: state_d = ST_FETCH;
    endcase
    cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // -------------------------------------------------------------------------
  // State register; reset wins over any pending transition or increment.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      op_q    <= 6'h00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Control strobes: Moore decode of the registered state. The only input
  // that reaches the outputs is mem_ready_i in FETCH, so ir/pc write fire in
  // exactly the cycle the fetch completes.
  // -------------------------------------------------------------------------
  always_comb begin
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    reg_write_o  = 1'b0;
    reg_dst_o    = 1'b0;
    alu_src_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    branch_o     = 1'b0;
    jump_o       = 1'b0;
    illegal_o    = 1'b0;
    alu_op3      = 3'b000;
    case (state_q)
      ST_FETCH: begin
        mem_read_o = 1'b1;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
        end
      end
      ST_DECODE: illegal_o = ~is_legal(op_q);
      ST_EXEC_R: alu_op3 = ALU_RTYPE;
      ST_EXEC_I: begin
        alu_src_o = 1'b1;
        alu_op3   = itype_alu(op_q);
      end
      // WB keeps the ALU result stable by repeating the EXEC controls.
      ST_WB: begin
        reg_write_o = 1'b1;
        if (op_q == OP_RTYPE) begin
          reg_dst_o = 1'b1;
          alu_op3   = ALU_RTYPE;
        end else begin
          alu_src_o = 1'b1;
          alu_op3   = itype_alu(op_q);
        end
      end
      ST_MEM_ADDR: begin
        alu_src_o = 1'b1;
        alu_op3   = ALU_ADD;
      end
      ST_MEM_RD: mem_read_o = 1'b1;
      ST_MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      ST_MEM_WR: mem_write_o = 1'b1;
      ST_BRANCH: begin
        branch_o = 1'b1;
        alu_op3  = ALU_SUB;
      end
`ifdef MULTICYCLE_DECODER_JUMP_EN
      ST_JUMP: begin
        jump_o     = 1'b1;
        pc_write_o = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign alu_op_o    = ALU_OP_W'(alu_op3);
  assign state_o     = state_q;
  assign instr_cnt_o = cnt_q;

endmodule

// File: tb/tb_multicycle_decoder.sv
// ---------------------------------------------------------------------------
// tb_multicycle_decoder
//   Instruction-level reference model: for each instruction the bench lists
//   the expected cycle sequence (state, strobes, ALU code, count) from the
//   instruction class and memory wait counts, then replays it against the
//   DUT one cycle at a time. CNT_W=4 so wrap-around is cheap to reach;
//   ALU_OP_W=4 exercises zero-extension of the ALU code.
// ---------------------------------------------------------------------------
module tb_multicycle_decoder;

  localparam int ALU_OP_W = 4;
  localparam int CNT_W    = 4;
`ifdef MULTICYCLE_DECODER_JUMP_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif

  // strobe vector bit weights, ordered as in obs below
  localparam logic [10:0] B_PC  = 11'h400, B_IR   = 11'h200, B_MRD  = 11'h100,
                          B_MWR = 11'h080, B_RW   = 11'h040, B_RDST = 11'h020,
                          B_ASRC= 11'h010, B_M2R  = 11'h008, B_BR   = 11'h004,
                          B_JMP = 11'h002, B_ILL  = 11'h001;

  logic                clk_i = 1'b0;
  logic                rst_i = 1'b1;
  logic [5:0]          instr_op_i = 6'h00;
  logic                mem_ready_i = 1'b0;
  logic                pc_write_o, ir_write_o, mem_read_o, mem_write_o;
  logic                reg_write_o, reg_dst_o, alu_src_o, mem_to_reg_o;
  logic                branch_o, jump_o, illegal_o;
  logic [ALU_OP_W-1:0] alu_op_o;
  logic [3:0]          state_o;
  logic [CNT_W-1:0]    instr_cnt_o;

  multicycle_decoder #(.ALU_OP_W(ALU_OP_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i), .mem_ready_i(mem_ready_i),
    .pc_write_o(pc_write_o), .ir_write_o(ir_write_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o),
    .alu_src_o(alu_src_o), .mem_to_reg_o(mem_to_reg_o), .branch_o(branch_o),
    .jump_o(jump_o), .illegal_o(illegal_o), .alu_op_o(alu_op_o),
    .state_o(state_o), .instr_cnt_o(instr_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // {state, strobes, alu_op, count}
  logic [22:0] obs;
  assign obs = {state_o, pc_write_o, ir_write_o, mem_read_o, mem_write_o,
                reg_write_o, reg_dst_o, alu_src_o, mem_to_reg_o, branch_o,
                jump_o, illegal_o, alu_op_o, instr_cnt_o};

  typedef struct packed {
    logic        rdy;
    logic [5:0]  op;
    logic [22:0] exp;
  } cyc_t;

  cyc_t       q[$];
  logic [3:0] mcnt;
  int         checks = 0;
  int         errors = 0;

  function automatic logic rb();
    return ($urandom_range(0, 1) != 0);
  endfunction

  function automatic logic [5:0] ro();
    return 6'($urandom);
  endfunction

  function void push(input logic rdy, input logic [5:0] op, input logic [3:0] st,
                     input logic [10:0] sb, input logic [2:0] alu);
    cyc_t c;
    c.rdy = rdy;
    c.op  = op;
    c.exp = {st, sb, 1'b0, alu, mcnt};
    q.push_back(c);
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return (op == 6'h00) || (op == 6'h08) || (op == 6'h0A) || (op == 6'h23) ||
           (op == 6'h2B) || (op == 6'h04) || (JUMP_EN && op == 6'h02);
  endfunction

  // Append the expected cycles of one instruction, starting in FETCH.
  // fw: fetch wait cycles, mw: memory wait cycles in MEM_RD/MEM_WR.
  function void model_instr(input logic [5:0] op, input int fw, input int mw);
    logic [2:0] a;
    for (int i = 0; i < fw; i++) push(1'b0, ro(), 4'd1, B_MRD, 3'b000);
    push(1'b1, op, 4'd1, B_PC | B_IR | B_MRD, 3'b000);
    if (!is_legal(op)) begin
      push(rb(), ro(), 4'd2, B_ILL, 3'b000);
      return;
    end
    push(rb(), ro(), 4'd2, 11'h000, 3'b000);
    case (op)
      6'h00: begin
        push(rb(), ro(), 4'd3, 11'h000, 3'b010);
        push(rb(), ro(), 4'd11, B_RW | B_RDST, 3'b010);
      end
      6'h08, 6'h0A: begin
        a = (op == 6'h08) ? 3'b100 : 3'b011;
        push(rb(), ro(), 4'd4, B_ASRC, a);
        push(rb(), ro(), 4'd11, B_RW | B_ASRC, a);
      end
      6'h23: begin
        push(rb(), ro(), 4'd5, B_ASRC, 3'b100);
        for (int i = 0; i < mw; i++) push(1'b0, ro(), 4'd6, B_MRD, 3'b000);
        push(1'b1, ro(), 4'd6, B_MRD, 3'b000);
        push(rb(), ro(), 4'd7, B_RW | B_M2R, 3'b000);
      end
      6'h2B: begin
        push(rb(), ro(), 4'd5, B_ASRC, 3'b100);
        for (int i = 0; i < mw; i++) push(1'b0, ro(), 4'd8, B_MWR, 3'b000);
        push(1'b1, ro(), 4'd8, B_MWR, 3'b000);
      end
      6'h04:   push(rb(), ro(), 4'd9, B_BR, 3'b101);
      default: push(rb(), ro(), 4'd10, B_JMP | B_PC, 3'b000);
    endcase
    mcnt = mcnt + 4'd1;
  endfunction

  task automatic test_reset();
    rst_i = 1'b1; mem_ready_i = 1'b1; instr_op_i = ro();
    @(negedge clk_i); @(negedge clk_i);
    #1; checks++;
    if (obs !== 23'd0) begin
      errors++; $display("FAIL reset_idle: got st=%0d strb=%b alu=%0d cnt=%0d want all zero",
                         obs[22:19], obs[18:8], obs[7:4], obs[3:0]);
    end
    rst_i = 1'b0;
    #1; checks++;
    if (obs !== 23'd0) begin
      errors++; $display("FAIL reset_release_idle: got st=%0d strb=%b alu=%0d cnt=%0d want all zero",
                         obs[22:19], obs[18:8], obs[7:4], obs[3:0]);
    end
    @(negedge clk_i);
    mem_ready_i = 1'b0;
    #1; checks++;
    if (obs !== {4'd1, B_MRD, 4'd0, 4'd0}) begin
      errors++; $display("FAIL reset_to_fetch: got st=%0d strb=%b alu=%0d cnt=%0d want st=1 strb=%b",
                         obs[22:19], obs[18:8], obs[7:4], obs[3:0], B_MRD);
    end
    mcnt = 4'd0;
    @(negedge clk_i);
  endtask

  task automatic test_alu_ops();
    cyc_t e;
    model_instr(6'h00, 0, 0);
    model_instr(6'h00, $urandom_range(1, 3), 0);
    model_instr(6'h08, $urandom_range(0, 2), 0);
    model_instr(6'h0A, $urandom_range(0, 2), 0);
    while (q.size() != 0) begin
      e = q.pop_front();
      mem_ready_i = e.rdy; instr_op_i = e.op; #1;
      checks++;
      if (obs !== e.exp) begin
        errors++; $display("FAIL alu_ops: got st=%0d strb=%b alu=%0d cnt=%0d want st=%0d strb=%b alu=%0d cnt=%0d",
          obs[22:19], obs[18:8], obs[7:4], obs[3:0], e.exp[22:19], e.exp[18:8], e.exp[7:4], e.exp[3:0]);
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_mem();
    cyc_t e;
    model_instr(6'h23, 0, 3);
    model_instr(6'h2B, 1, 0);
    model_instr(6'h3F, 0, 0);
    model_instr(6'h2B, 0, 2);
    model_instr(6'h23, 2, 0);
    while (q.size() != 0) begin
      e = q.pop_front();
      mem_ready_i = e.rdy; instr_op_i = e.op; #1;
      checks++;
      if (obs !== e.exp) begin
        errors++; $display("FAIL mem_illegal: got st=%0d strb=%b alu=%0d cnt=%0d want st=%0d strb=%b alu=%0d cnt=%0d",
          obs[22:19], obs[18:8], obs[7:4], obs[3:0], e.exp[22:19], e.exp[18:8], e.exp[7:4], e.exp[3:0]);
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_jump();
    cyc_t e;
    model_instr(6'h02, 0, 0);
    model_instr(6'h04, 0, 0);
    model_instr(6'h02, 1, 0);
    while (q.size() != 0) begin
      e = q.pop_front();
      mem_ready_i = e.rdy; instr_op_i = e.op; #1;
      checks++;
      if (obs !== e.exp) begin
        errors++; $display("FAIL jump: got st=%0d strb=%b alu=%0d cnt=%0d want st=%0d strb=%b alu=%0d cnt=%0d",
          obs[22:19], obs[18:8], obs[7:4], obs[3:0], e.exp[22:19], e.exp[18:8], e.exp[7:4], e.exp[3:0]);
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_wrap();
    cyc_t e;
    rst_i = 1'b1; @(negedge clk_i);
    rst_i = 1'b0; @(negedge clk_i);
    mcnt = 4'd0;
    for (int i = 0; i < 16; i++) model_instr(6'h04, $urandom_range(0, 1), 0);
    while (q.size() != 0) begin
      e = q.pop_front();
      mem_ready_i = e.rdy; instr_op_i = e.op; #1;
      checks++;
      if (obs !== e.exp) begin
        errors++; $display("FAIL beq_wrap: got st=%0d strb=%b alu=%0d cnt=%0d want st=%0d strb=%b alu=%0d cnt=%0d",
          obs[22:19], obs[18:8], obs[7:4], obs[3:0], e.exp[22:19], e.exp[18:8], e.exp[7:4], e.exp[3:0]);
      end
      @(negedge clk_i);
    end
    #1; checks++;
    if (instr_cnt_o !== 4'd0 || state_o !== 4'd1) begin
      errors++; $display("FAIL wrap_zero: got cnt=%0d st=%0d want cnt=0 st=1", instr_cnt_o, state_o);
    end
  endtask

  task automatic test_random();
    cyc_t e;
    logic [5:0] pool [7] = '{6'h00, 6'h08, 6'h0A, 6'h23, 6'h2B, 6'h04, 6'h02};
    logic [5:0] op;
    for (int n = 0; n < 40; n++) begin
      op = ($urandom_range(0, 9) < 7) ? pool[$urandom_range(0, 6)] : ro();
      model_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    while (q.size() != 0) begin
      e = q.pop_front();
      mem_ready_i = e.rdy; instr_op_i = e.op; #1;
      checks++;
      if (obs !== e.exp) begin
        errors++; $display("FAIL random: got st=%0d strb=%b alu=%0d cnt=%0d want st=%0d strb=%b alu=%0d cnt=%0d",
          obs[22:19], obs[18:8], obs[7:4], obs[3:0], e.exp[22:19], e.exp[18:8], e.exp[7:4], e.exp[3:0]);
      end
      @(negedge clk_i);
    end
  endtask

  // Reset lands while waiting in a memory state with mem_ready_i high, so
  // without reset priority the FSM would advance (and a store would retire).
  task automatic test_reset_mid_wait();
    cyc_t e;
    int   n_wait;
    for (int k = 0; k < 2; k++) begin
      model_instr((k == 0) ? 6'h23 : 6'h2B, 1, 5);
      n_wait = 0;
      while (q.size() != 0 && n_wait < 2) begin
        e = q.pop_front();
        mem_ready_i = e.rdy; instr_op_i = e.op; #1;
        checks++;
        if (obs !== e.exp) begin
          errors++; $display("FAIL reset_mid_pre: got st=%0d strb=%b alu=%0d cnt=%0d want st=%0d strb=%b alu=%0d cnt=%0d",
            obs[22:19], obs[18:8], obs[7:4], obs[3:0], e.exp[22:19], e.exp[18:8], e.exp[7:4], e.exp[3:0]);
        end
        if (e.exp[22:19] == 4'd6 || e.exp[22:19] == 4'd8) n_wait++;
        @(negedge clk_i);
      end
      q.delete();
      rst_i = 1'b1; mem_ready_i = 1'b1;
      @(negedge clk_i);
      #1; checks++;
      if (obs !== 23'd0) begin
        errors++; $display("FAIL reset_mid_wait: got st=%0d strb=%b alu=%0d cnt=%0d want all zero",
                           obs[22:19], obs[18:8], obs[7:4], obs[3:0]);
      end
      rst_i = 1'b0;
      @(negedge clk_i);
      mcnt = 4'd0;
    end
  endtask

  initial begin
    mcnt = 4'd0;
    @(negedge clk_i);
    test_reset();
    test_alu_ops();
    test_mem();
    test_jump();
    test_random();
    test_wrap();
    test_reset_mid_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach the summary line");
    $fatal(1);
  end

endmodule
